regfile_write_arbiter: RTL and testbench

- Owns the single register-file write port.
- Shares the port between the in-order writeback stage and a long-latency unit (LLU, e.g. mul/div). The LLU returns results out of band.
- LLU results are held in a small FIFO and drained into idle writeback slots.
- When the LLU must win, the block asserts a stall that holds the writeback pipeline register. It also exposes a pending-destination lookup so decode can block hazards.

---
 rtl/regfile_arb_pkg.sv | 19 +
 rtl/llu_result_fifo.sv | 99 +++++++++
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_arb_pkg
//  Brief    : Shared types and widths for the register-file write arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // One buffered long-latency result: destination register and its value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } llu_entry_t;

endpackage
`default_nettype wire

// File: rtl/llu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : llu_result_fifo
//  Brief    : Synchronous FIFO for LLU results with head peek, occupancy and
//             a parallel destination-register match over valid entries.
//  Revision : 1.0 - initial release
// ============================================================================
module llu_result_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  llu_entry_t              i_push_entry,
    input  logic                    i_pop,
    output llu_entry_t              o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty,
    input  logic [REG_ADDR_W-1:0]   i_query_rd,
    output logic                    o_query_hit
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    llu_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_push;
    logic                w_pop;
    logic [DEPTH-1:0]    w_valid_next;
    logic [DEPTH-1:0]    w_match;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Guard against overflow/underflow so the pointers can never diverge.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    // Per-slot valid bits: clear the popped slot, set the pushed slot.
    always_comb begin
        w_valid_next = r_valid;
        if (w_pop) begin
            w_valid_next[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_valid_next[r_wr_ptr] = 1'b1;
        end
    end

    // Storage array; contents are qualified by r_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers, occupancy and valid bits; pointers wrap at power-of-two DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            r_valid <= w_valid_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Parallel destination compare against every slot holding a result.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign w_match[gi] = r_valid[gi] && (r_mem[gi].rd == i_query_rd);
    end

    // x0 is never a hazard, so a zero query never hits.
    assign o_query_hit = (i_query_rd != '0) && (|w_match);

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Brief    : Shares the single register-file write port between the
//             writeback stage and buffered long-latency-unit results, with
//             bounded starvation of the buffer head.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    wb_valid_i,
    input  logic                    wb_reg_write_i,
    input  logic [REG_ADDR_W-1:0]   wb_rd_i,
    input  logic [XLEN-1:0]         wb_result_i,
    input  logic                    llu_valid_i,
    input  logic [REG_ADDR_W-1:0]   llu_rd_i,
    input  logic [XLEN-1:0]         llu_data_i,
    output logic                    llu_ready_o,
    input  logic [REG_ADDR_W-1:0]   query_rd_i,
    output logic                    query_hit_o,
    output logic                    rf_we_o,
    output logic [REG_ADDR_W-1:0]   rf_rd_o,
    output logic [XLEN-1:0]         rf_wdata_o,
    output logic                    stall_w_o,
    output logic [$clog2(DEPTH):0]  buf_count_o
);

    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    logic                w_pipe_req;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic                w_wait_sat;
    logic                w_llu_grant;
    logic                w_pipe_grant;
    llu_entry_t          w_push_entry;
    llu_entry_t          w_head;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    assign w_pipe_req = wb_valid_i & wb_reg_write_i & (wb_rd_i != '0);

    // Ready depends only on registered occupancy; rd=0 results are accepted
    // but never stored since x0 writes are architecturally discarded.
    assign llu_ready_o       = ~w_full;
    assign w_push            = llu_valid_i & llu_ready_o & (llu_rd_i != '0);
    assign w_push_entry.rd   = llu_rd_i;
    assign w_push_entry.data = llu_data_i;

    // Buffer wins when the pipe is idle, the buffer is full, or the head has
    // been passed over long enough.
    assign w_wait_sat   = (r_wait_cnt == c_WAIT_W'(MAX_WAIT));
    assign w_llu_grant  = ~w_empty & (~w_pipe_req | w_full | w_wait_sat);
    assign w_pipe_grant = w_pipe_req & ~w_llu_grant;
    assign stall_w_o    = w_pipe_req & w_llu_grant;

    llu_result_fifo #(
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk_i),
        .rst          (reset_i),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_llu_grant),
        .o_head       (w_head),
        .o_count      (buf_count_o),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .i_query_rd   (query_rd_i),
        .o_query_hit  (query_hit_o)
    );

    // Drive the write port from whichever side holds the grant.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_rd_o    = '0;
        rf_wdata_o = '0;
        if (w_llu_grant) begin
            rf_we_o    = 1'b1;
            rf_rd_o    = w_head.rd;
            rf_wdata_o = w_head.data;
        end else if (w_pipe_grant) begin
            rf_we_o    = 1'b1;
            rf_rd_o    = wb_rd_i;
            rf_wdata_o = wb_result_i;
        end
    end

    // Count cycles the current head has been denied, saturating at MAX_WAIT.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wait_cnt <= '0;
        end else if (w_llu_grant || w_empty) begin
            r_wait_cnt <= '0;
        end else if (!w_wait_sat) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_arbiter
//  Brief    : Self-checking bench for regfile_write_arbiter: vector table,
//             directed corner sequences and random traffic against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk_i;
    logic        reset_i;
    logic        wb_valid_i;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_result_i;
    logic        llu_valid_i;
    logic [4:0]  llu_rd_i;
    logic [31:0] llu_data_i;
    logic        llu_ready_o;
    logic [4:0]  query_rd_i;
    logic        query_hit_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wdata_o;
    logic        stall_w_o;
    logic [2:0]  buf_count_o;

    regfile_write_arbiter #(
        .DEPTH          (DEPTH),
        .MAX_WAIT       (MAX_WAIT)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .wb_valid_i     (wb_valid_i),
        .wb_reg_write_i (wb_reg_write_i),
        .wb_rd_i        (wb_rd_i),
        .wb_result_i    (wb_result_i),
        .llu_valid_i    (llu_valid_i),
        .llu_rd_i       (llu_rd_i),
        .llu_data_i     (llu_data_i),
        .llu_ready_o    (llu_ready_o),
        .query_rd_i     (query_rd_i),
        .query_hit_o    (query_hit_o),
        .rf_we_o        (rf_we_o),
        .rf_rd_o        (rf_rd_o),
        .rf_wdata_o     (rf_wdata_o),
        .stall_w_o      (stall_w_o),
        .buf_count_o    (buf_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of pending results and a denial-age counter.
    llu_entry_t m_q[$];
    int         m_wait;
    bit         m_llu_win;
    bit         m_nonempty;
    bit         m_full;
    bit         m_stall;

    typedef struct {
        logic        wv;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic [4:0]  qrd;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_stall;
        logic        e_ready;
        logic        e_hit;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        wb_valid_i     = 1'b0;
        wb_reg_write_i = 1'b0;
        wb_rd_i        = 5'd0;
        wb_result_i    = 32'd0;
        llu_valid_i    = 1'b0;
        llu_rd_i       = 5'd0;
        llu_data_i     = 32'd0;
        query_rd_i     = 5'd0;
    endtask

    task automatic set_pipe(input logic [4:0] rd, input logic [31:0] res);
        wb_valid_i     = 1'b1;
        wb_reg_write_i = 1'b1;
        wb_rd_i        = rd;
        wb_result_i    = res;
    endtask

    task automatic set_llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        llu_valid_i = v;
        llu_rd_i    = rd;
        llu_data_i  = d;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wait  = 0;
        m_stall = 1'b0;
    endtask

    // Settle, predict this cycle's outputs from the model, compare all outputs.
    task automatic cyc_pre();
        bit          pipe_req;
        bit          pipe_win;
        bit          hit;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        #1;
        pipe_req   = wb_valid_i && wb_reg_write_i && (wb_rd_i != 5'd0);
        m_nonempty = (m_q.size() > 0);
        m_full     = (m_q.size() == DEPTH);
        m_llu_win  = m_nonempty && (!pipe_req || m_full || (m_wait >= MAX_WAIT));
        pipe_win   = pipe_req && !m_llu_win;
        m_stall    = pipe_req && m_llu_win;
        e_rd = 5'd0;
        e_wd = 32'd0;
        if (m_llu_win) begin
            e_rd = m_q[0].rd;
            e_wd = m_q[0].data;
        end else if (pipe_win) begin
            e_rd = wb_rd_i;
            e_wd = wb_result_i;
        end
        hit = 1'b0;
        foreach (m_q[i]) begin
            if (query_rd_i != 5'd0 && m_q[i].rd == query_rd_i) hit = 1'b1;
        end
        check("rf_we",     32'(rf_we_o),     32'(m_llu_win || pipe_win));
        check("rf_rd",     32'(rf_rd_o),     32'(e_rd));
        check("rf_wdata",  rf_wdata_o,       e_wd);
        check("stall_w",   32'(stall_w_o),   32'(m_stall));
        check("llu_ready", 32'(llu_ready_o), 32'(!m_full));
        check("query_hit", 32'(query_hit_o), 32'(hit));
        check("buf_count", 32'(buf_count_o), 32'(m_q.size()));
    endtask

    // Advance through the clock edge and update the model with the same rules.
    task automatic cyc_post();
        llu_entry_t e;
        @(posedge clk_i);
        if (m_llu_win) void'(m_q.pop_front());
        if (llu_valid_i && !m_full && llu_rd_i != 5'd0) begin
            e.rd   = llu_rd_i;
            e.data = llu_data_i;
            m_q.push_back(e);
        end
        if (m_llu_win || !m_nonempty) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        @(negedge clk_i);
    endtask

    task automatic cyc();
        cyc_pre();
        cyc_post();
    endtask

    initial begin
        set_idle();
        model_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_we",    32'(rf_we_o),     32'd0);
        check("rst_stall", 32'(stall_w_o),   32'd0);
        check("rst_ready", 32'(llu_ready_o), 32'd1);
        check("rst_hit",   32'(query_hit_o), 32'd0);
        check("rst_count", 32'(buf_count_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // ---------------- vector table from empty ----------------
        tbl[0]  = '{1'b0,1'b0,5'd0, 32'h0,     1'b1,5'd5,32'hDEADBEEF,5'd0, 1'b0,5'd0, 32'h0,       1'b0,1'b1,1'b0,3'd0};
        tbl[1]  = '{1'b0,1'b0,5'd0, 32'h0,     1'b1,5'd3,32'h33,      5'd5, 1'b1,5'd5, 32'hDEADBEEF,1'b0,1'b1,1'b1,3'd1};
        tbl[2]  = '{1'b1,1'b1,5'd10,32'hA0A0,  1'b1,5'd9,32'h99,      5'd3, 1'b1,5'd10,32'hA0A0,    1'b0,1'b1,1'b1,3'd1};
        tbl[3]  = '{1'b1,1'b1,5'd10,32'hA0A0,  1'b0,5'd0,32'h0,       5'd9, 1'b1,5'd10,32'hA0A0,    1'b0,1'b1,1'b1,3'd2};
        tbl[4]  = '{1'b1,1'b1,5'd10,32'hA0A0,  1'b0,5'd0,32'h0,       5'd4, 1'b1,5'd10,32'hA0A0,    1'b0,1'b1,1'b0,3'd2};
        tbl[5]  = '{1'b1,1'b1,5'd10,32'hA0A0,  1'b0,5'd0,32'h0,       5'd0, 1'b1,5'd10,32'hA0A0,    1'b0,1'b1,1'b0,3'd2};
        tbl[6]  = '{1'b0,1'b0,5'd0, 32'h0,     1'b1,5'd0,32'h1234,    5'd3, 1'b1,5'd3, 32'h33,      1'b0,1'b1,1'b1,3'd2};
        tbl[7]  = '{1'b0,1'b0,5'd0, 32'h0,     1'b0,5'd0,32'h0,       5'd9, 1'b1,5'd9, 32'h99,      1'b0,1'b1,1'b1,3'd1};
        tbl[8]  = '{1'b0,1'b0,5'd0, 32'h0,     1'b0,5'd0,32'h0,       5'd9, 1'b0,5'd0, 32'h0,       1'b0,1'b1,1'b0,3'd0};
        tbl[9]  = '{1'b1,1'b0,5'd7, 32'h77,    1'b0,5'd0,32'h0,       5'd0, 1'b0,5'd0, 32'h0,       1'b0,1'b1,1'b0,3'd0};
        tbl[10] = '{1'b1,1'b1,5'd0, 32'h77,    1'b0,5'd0,32'h0,       5'd0, 1'b0,5'd0, 32'h0,       1'b0,1'b1,1'b0,3'd0};
        tbl[11] = '{1'b0,1'b1,5'd7, 32'h77,    1'b0,5'd0,32'h0,       5'd0, 1'b0,5'd0, 32'h0,       1'b0,1'b1,1'b0,3'd0};
        for (int i = 0; i < 12; i++) begin
            wb_valid_i     = tbl[i].wv;
            wb_reg_write_i = tbl[i].ww;
            wb_rd_i        = tbl[i].wrd;
            wb_result_i    = tbl[i].wres;
            set_llu(tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
            query_rd_i     = tbl[i].qrd;
            cyc_pre();
            check("tbl_we",    32'(rf_we_o),     32'(tbl[i].e_we));
            check("tbl_rd",    32'(rf_rd_o),     32'(tbl[i].e_rd));
            check("tbl_wdata", rf_wdata_o,       tbl[i].e_wd);
            check("tbl_stall", 32'(stall_w_o),   32'(tbl[i].e_stall));
            check("tbl_ready", 32'(llu_ready_o), 32'(tbl[i].e_ready));
            check("tbl_hit",   32'(query_hit_o), 32'(tbl[i].e_hit));
            check("tbl_count", 32'(buf_count_o), 32'(tbl[i].e_cnt));
            cyc_post();
        end

        // ---------------- fill to full under constant pipe pressure ----------------
        set_idle();
        set_pipe(5'd7, 32'h7777);
        for (int i = 1; i <= 4; i++) begin
            set_llu(1'b1, 5'(i), 32'h100 + 32'(i));
            cyc();
        end
        set_llu(1'b0, 5'd0, 32'd0);
        cyc_pre();
        check("full_stall", 32'(stall_w_o),   32'd1);
        check("full_ready", 32'(llu_ready_o), 32'd0);
        check("full_rd",    32'(rf_rd_o),     32'd1);
        check("full_count", 32'(buf_count_o), 32'd4);
        cyc_post();
        cyc_pre();
        check("after_full_rd",    32'(rf_rd_o),     32'd7);
        check("after_full_stall", 32'(stall_w_o),   32'd0);
        check("after_full_count", 32'(buf_count_o), 32'd3);
        check("after_full_ready", 32'(llu_ready_o), 32'd1);
        cyc_post();
        set_idle();
        repeat (4) cyc();

        // ---------------- starvation bound ----------------
        set_llu(1'b1, 5'd12, 32'hC0FFEE12);
        cyc();
        set_llu(1'b0, 5'd0, 32'd0);
        set_pipe(5'd20, 32'h20202020);
        for (int i = 0; i < MAX_WAIT; i++) begin
            cyc_pre();
            check("starve_pipe_rd", 32'(rf_rd_o),   32'd20);
            check("starve_nostall", 32'(stall_w_o), 32'd0);
            cyc_post();
        end
        cyc_pre();
        check("starve_llu_rd",   32'(rf_rd_o),   32'd12);
        check("starve_llu_data", rf_wdata_o,     32'hC0FFEE12);
        check("starve_stall",    32'(stall_w_o), 32'd1);
        cyc_post();
        cyc_pre();
        check("starve_retry_rd", 32'(rf_rd_o),     32'd20);
        check("starve_retry_st", 32'(stall_w_o),   32'd0);
        check("starve_empty",    32'(buf_count_o), 32'd0);
        cyc_post();

        // ---------------- push+pop at count 2, order across wrap ----------------
        set_idle();
        set_pipe(5'd30, 32'h3030);
        set_llu(1'b1, 5'd21, 32'h2100);
        cyc();
        set_llu(1'b1, 5'd22, 32'h2200);
        cyc();
        set_idle();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_llu(1'b1, 5'(23 + i), 32'h2300 + 32'(i * 256));
            else       set_llu(1'b0, 5'd0, 32'd0);
            cyc_pre();
            check("order_we", 32'(rf_we_o), 32'd1);
            check("order_rd", 32'(rf_rd_o), 32'(21 + i));
            if (i < 4) check("pushpop_count", 32'(buf_count_o), 32'd2);
            cyc_post();
        end
        set_idle();
        cyc();

        // ---------------- asynchronous reset with 3 buffered ----------------
        set_pipe(5'd7, 32'h7);
        for (int i = 1; i <= 3; i++) begin
            set_llu(1'b1, 5'(i), 32'h500 + 32'(i));
            cyc();
        end
        set_idle();
        query_rd_i = 5'd2;
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_count", 32'(buf_count_o), 32'd0);
        check("arst_ready", 32'(llu_ready_o), 32'd1);
        check("arst_we",    32'(rf_we_o),     32'd0);
        check("arst_stall", 32'(stall_w_o),   32'd0);
        check("arst_hit",   32'(query_hit_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
        cyc_pre();
        check("post_rst_count", 32'(buf_count_o), 32'd0);
        check("post_rst_ready", 32'(llu_ready_o), 32'd1);
        cyc_post();

        // ---------------- random traffic against the model ----------------
        for (int n = 0; n < 400; n++) begin
            if (!m_stall) begin
                wb_valid_i     = ($urandom_range(0, 9) < 7);
                wb_reg_write_i = ($urandom_range(0, 3) != 0);
                wb_rd_i        = 5'($urandom_range(0, 7));
                wb_result_i    = $urandom;
            end
            llu_valid_i = ($urandom_range(0, 1) == 1);
            llu_rd_i    = 5'($urandom_range(0, 7));
            llu_data_i  = $urandom;
            query_rd_i  = 5'($urandom_range(0, 7));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
